// File: rtl/e203_exu_dsp_shift_pipe.sv
// Pipelined SIMD shift unit for the EXU DSP path: SLL/SRL/SRA/ROR, rounding SRA and saturating left shift
// on 1x32, 2x16 or 4x8 lanes, with valid/ready handshakes on both sides and a flush.
module e203_exu_dsp_shift_pipe #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int PIPE    = 2,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [2:0]         i_op,
    input  logic [1:0]         i_lane,
    input  logic [XLEN-1:0]    i_op1,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [XLEN-1:0]    o_res,
    output logic               o_ov,
    output logic [TAG_W-1:0]   o_tag
);

    localparam int W2 = 2 * XLEN;

    localparam logic [2:0] OP_SLL   = 3'd0;
    localparam logic [2:0] OP_SRL   = 3'd1;
    localparam logic [2:0] OP_SRA   = 3'd2;
    localparam logic [2:0] OP_ROR   = 3'd3;
    localparam logic [2:0] OP_SRA_R = 3'd4;
    localparam logic [2:0] OP_KSLL  = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] raw;
        logic            rnd;
        logic            ov;
        logic            sgn;
    } laneRes_t;

    // Raw shift of one lane of width lw, computed in double width so shifted-out bits stay visible.
    function automatic laneRes_t laneCalc(input logic [XLEN-1:0] x, input int lw,
                                          input logic [2:0] op, input logic [SHAMT_W-1:0] shamt);
        laneRes_t r;
        logic [W2-1:0] allOnes, mask, xe, sx, prod, tmp, expHi;
        int s;
        allOnes = '1;
        mask    = allOnes >> (W2 - lw);
        xe      = {{XLEN{1'b0}}, x} & mask;
        s       = int'(shamt) & (lw - 1);
        r       = '0;
        prod    = '0;
        tmp     = xe >> (lw - 1);
        r.sgn   = tmp[0];
        sx      = r.sgn ? (xe | ~mask) : xe;
        case (op)
            OP_SLL:  prod = xe << s;
            OP_SRL:  prod = xe >> s;
            OP_SRA:  prod = sx >> s;
            OP_ROR:  prod = (xe >> s) | (xe << (lw - s));
            OP_SRA_R: begin
                prod = sx >> s;
                if (s > 0) begin
                    tmp   = xe >> (s - 1);
                    r.rnd = tmp[0];
                end
            end
            OP_KSLL: begin
                prod  = sx << s;
                tmp   = prod >> (lw - 1);
                expHi = r.sgn ? (allOnes >> (lw - 1)) : '0;
                r.ov  = (tmp != expHi);
            end
            default: prod = '0;
        endcase
        r.raw = XLEN'(prod & mask);
        return r;
    endfunction

    // Second half of the datapath: rounding add and saturation per lane; returns {ov, res}.
    function automatic logic [XLEN:0] resolve(input logic [XLEN-1:0] raw, input logic [1:0] mode,
                                              input logic [2:0] op, input logic [3:0] rnd,
                                              input logic [3:0] ovl, input logic [3:0] sgn);
        logic [XLEN-1:0] res, ones, mask, v;
        int lw, nl;
        lw   = XLEN >> mode;
        nl   = 1 << mode;
        ones = '1;
        mask = ones >> (XLEN - lw);
        res  = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < nl) begin
                v = (raw >> (j * lw)) & mask;
                if (op == OP_SRA_R)
                    v = (v + {{(XLEN-1){1'b0}}, rnd[j]}) & mask;
                else if (op == OP_KSLL && ovl[j])
                    v = sgn[j] ? (mask ^ (mask >> 1)) : (mask >> 1);
                res = res | (v << (j * lw));
            end
        end
        return {(op == OP_KSLL) && (|ovl), res};
    endfunction

    logic [1:0]      laneMode;
    int              laneW;
    int              nLanes;
    laneRes_t        lr;
    logic [XLEN-1:0] shiftRaw_d;
    logic [3:0]      rnd_d, ovl_d, sgn_d;

    logic            outValid_q;
    logic [XLEN-1:0] outRes_q;
    logic            outOv_q;
    logic [TAG_W-1:0] outTag_q;

    always_comb begin
        laneMode   = (i_lane == 2'd3) ? 2'd0 : i_lane;
        laneW      = XLEN >> laneMode;
        nLanes     = 1 << laneMode;
        shiftRaw_d = '0;
        rnd_d      = '0;
        ovl_d      = '0;
        sgn_d      = '0;
        lr         = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < nLanes) begin
                lr         = laneCalc(i_op1 >> (j * laneW), laneW, i_op, i_shamt);
                shiftRaw_d = shiftRaw_d | (lr.raw << (j * laneW));
                rnd_d[j]   = lr.rnd;
                ovl_d[j]   = lr.ov;
                sgn_d[j]   = lr.sgn;
            end
        end
    end

    assign o_valid = outValid_q;
    assign o_res   = outRes_q;
    assign o_ov    = outOv_q;
    assign o_tag   = outTag_q;

    generate
        if (PIPE == 1) begin : g_pipe1
            logic            ld;
            logic [XLEN:0]   fin;

            assign ld      = !outValid_q || o_ready;
            assign i_ready = ld;
            assign fin     = resolve(shiftRaw_d, laneMode, i_op, rnd_d, ovl_d, sgn_d);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    outValid_q <= 1'b0;
                    outRes_q   <= '0;
                    outOv_q    <= 1'b0;
                    outTag_q   <= '0;
                end else begin
                    if (i_flush)
                        outValid_q <= 1'b0;
                    else if (ld)
                        outValid_q <= i_valid;
                    if (ld) begin
                        outRes_q <= fin[XLEN-1:0];
                        outOv_q  <= fin[XLEN];
                        outTag_q <= i_tag;
                    end
                end
            end
        end else begin : g_pipe2
            logic             s0Valid_q;
            logic [XLEN-1:0]  s0Raw_q;
            logic [2:0]       s0Op_q;
            logic [1:0]       s0Mode_q;
            logic [3:0]       s0Rnd_q, s0Ovl_q, s0Sgn_q;
            logic [TAG_W-1:0] s0Tag_q;
            logic             ld0, ld1;
            logic [XLEN:0]    fin;

            // Each stage may load when empty or when the stage ahead of it is loading.
            assign ld1     = !outValid_q || o_ready;
            assign ld0     = !s0Valid_q || ld1;
            assign i_ready = ld0;
            assign fin     = resolve(s0Raw_q, s0Mode_q, s0Op_q, s0Rnd_q, s0Ovl_q, s0Sgn_q);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s0Valid_q  <= 1'b0;
                    s0Raw_q    <= '0;
                    s0Op_q     <= '0;
                    s0Mode_q   <= '0;
                    s0Rnd_q    <= '0;
                    s0Ovl_q    <= '0;
                    s0Sgn_q    <= '0;
                    s0Tag_q    <= '0;
                    outValid_q <= 1'b0;
                    outRes_q   <= '0;
                    outOv_q    <= 1'b0;
                    outTag_q   <= '0;
                end else begin
                    if (i_flush)
                        s0Valid_q <= 1'b0;
                    else if (ld0)
                        s0Valid_q <= i_valid;
                    if (ld0) begin
                        s0Raw_q  <= shiftRaw_d;
                        s0Op_q   <= i_op;
                        s0Mode_q <= laneMode;
                        s0Rnd_q  <= rnd_d;
                        s0Ovl_q  <= ovl_d;
                        s0Sgn_q  <= sgn_d;
                        s0Tag_q  <= i_tag;
                    end
                    if (i_flush)
                        outValid_q <= 1'b0;
                    else if (ld1)
                        outValid_q <= s0Valid_q;
                    if (ld1) begin
                        outRes_q <= fin[XLEN-1:0];
                        outOv_q  <= fin[XLEN];
                        outTag_q <= s0Tag_q;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_e203_exu_dsp_shift_pipe.sv
// Directed bench for e203_exu_dsp_shift_pipe (PIPE=2): vector table for lane/op results,
// plus hand-written back-pressure, flush and async-reset sequences.
module tb_e203_exu_dsp_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_flush;
    logic        i_valid;
    logic        i_ready;
    logic [2:0]  i_op;
    logic [1:0]  i_lane;
    logic [31:0] i_op1;
    logic [4:0]  i_shamt;
    logic [4:0]  i_tag;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_res;
    logic        o_ov;
    logic [4:0]  o_tag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  lane;
        logic [31:0] op1;
        logic [4:0]  shamt;
        logic [31:0] expRes;
        logic        expOv;
    } vec_t;

    vec_t vecs[17];

    e203_exu_dsp_shift_pipe #(.XLEN(32), .SHAMT_W(5), .PIPE(2), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .i_ready(i_ready),
        .i_op(i_op), .i_lane(i_lane), .i_op1(i_op1), .i_shamt(i_shamt), .i_tag(i_tag),
        .o_valid(o_valid), .o_ready(o_ready), .o_res(o_res), .o_ov(o_ov), .o_tag(o_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [1:0] lane, input logic [31:0] op1,
                                input logic [4:0] shamt, input logic [31:0] expRes, input logic expOv);
        vec_t v;
        v.op = op; v.lane = lane; v.op1 = op1; v.shamt = shamt; v.expRes = expRes; v.expOv = expOv;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] lane, input logic [31:0] op1,
                                 input logic [4:0] shamt, input logic [4:0] tag);
        int waitCnt;
        i_valid = 1'b1; i_op = op; i_lane = lane; i_op1 = op1; i_shamt = shamt; i_tag = tag;
        #1;
        waitCnt = 0;
        while (!i_ready && waitCnt < 20) begin
            @(negedge clk); #1;
            waitCnt++;
        end
        if (!i_ready) checkOutput("accept_timeout", 32'(i_ready), 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Counts negedges since acceptance until o_valid, bounded.
    task automatic waitResult(output int lat);
        lat = 1;
        while (!o_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, accepted, outCount, lastC, gaps, seen;
        logic fire;
        logic [4:0] tagNext;

        vecs[0]  = mk(3'd0, 2'd0, 32'h00000001, 5'd31, 32'h80000000, 1'b0);
        vecs[1]  = mk(3'd2, 2'd2, 32'h807FF001, 5'd4,  32'hF807FF00, 1'b0);
        vecs[2]  = mk(3'd3, 2'd2, 32'h01020304, 5'd9,  32'h80018102, 1'b0);
        vecs[3]  = mk(3'd4, 2'd1, 32'h0003FFFD, 5'd1,  32'h0002FFFF, 1'b0);
        vecs[4]  = mk(3'd5, 2'd1, 32'h4000FFFF, 5'd1,  32'h7FFFFFFE, 1'b1);
        vecs[5]  = mk(3'd1, 2'd0, 32'h80000000, 5'd4,  32'h08000000, 1'b0);
        vecs[6]  = mk(3'd2, 2'd0, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0);
        vecs[7]  = mk(3'd3, 2'd0, 32'h12345678, 5'd8,  32'h78123456, 1'b0);
        vecs[8]  = mk(3'd0, 2'd1, 32'h00018001, 5'd17, 32'h00020002, 1'b0);
        vecs[9]  = mk(3'd4, 2'd0, 32'h00000005, 5'd0,  32'h00000005, 1'b0);
        vecs[10] = mk(3'd5, 2'd2, 32'h807F01C0, 5'd1,  32'h807F0280, 1'b1);
        vecs[11] = mk(3'd5, 2'd0, 32'hFFFFFFFF, 5'd31, 32'h80000000, 1'b0);
        vecs[12] = mk(3'd6, 2'd0, 32'hDEADBEEF, 5'd3,  32'h00000000, 1'b0);
        vecs[13] = mk(3'd1, 2'd3, 32'hF0000000, 5'd28, 32'h0000000F, 1'b0);
        vecs[14] = mk(3'd4, 2'd2, 32'h0FF10080, 5'd4,  32'h01FF00F8, 1'b0);
        vecs[15] = mk(3'd5, 2'd0, 32'h7FFFFFFF, 5'd0,  32'h7FFFFFFF, 1'b0);
        vecs[16] = mk(3'd3, 2'd1, 32'h00018000, 5'd15, 32'h00020001, 1'b0);

        rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
        i_op = '0; i_lane = '0; i_op1 = '0; i_shamt = '0; i_tag = '0;
        #12;
        checkOutput("reset_o_valid", 32'(o_valid), 32'd0);
        checkOutput("reset_o_res", o_res, 32'd0);
        checkOutput("reset_o_ov", 32'(o_ov), 32'd0);
        checkOutput("reset_o_tag", 32'(o_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 17; k++) begin
            applyStimulus(vecs[k].op, vecs[k].lane, vecs[k].op1, vecs[k].shamt, 5'(k));
            waitResult(lat);
            checkOutput($sformatf("vec%0d_latency", k), 32'(lat), 32'd2);
            checkOutput($sformatf("vec%0d_res", k), o_res, vecs[k].expRes);
            checkOutput($sformatf("vec%0d_ov", k), 32'(o_ov), 32'(vecs[k].expOv));
            checkOutput($sformatf("vec%0d_tag", k), 32'(o_tag), k);
        end
        @(negedge clk);

        // Back-pressure: only two ops fit while the consumer stalls.
        o_ready = 1'b0; tagNext = 5'd0; accepted = 0;
        for (int c = 0; c < 5; c++) begin
            i_valid = 1'b1; i_op = 3'd0; i_lane = 2'd0; i_op1 = 32'(tagNext) + 32'd1;
            i_shamt = 5'd1; i_tag = tagNext;
            #1;
            fire = i_ready;
            @(negedge clk);
            if (fire) begin
                accepted++;
                tagNext++;
            end
        end
        checkOutput("bp_accepted", 32'(accepted), 32'd2);
        #1;
        checkOutput("bp_i_ready_low", 32'(i_ready), 32'd0);
        checkOutput("bp_hold_valid", 32'(o_valid), 32'd1);
        checkOutput("bp_hold_tag", 32'(o_tag), 32'd0);
        checkOutput("bp_hold_res", o_res, 32'd2);
        @(negedge clk);
        o_ready = 1'b1; outCount = 0; lastC = 0; gaps = 0;
        for (int c = 0; c < 30 && outCount < 6; c++) begin
            if (o_valid) begin
                checkOutput("stream_tag", 32'(o_tag), 32'(outCount));
                checkOutput("stream_res", o_res, 32'((outCount + 1) * 2));
                if (outCount > 0 && c != lastC + 1) gaps++;
                lastC = c;
                outCount++;
            end
            if (tagNext < 5'd6) begin
                i_valid = 1'b1; i_op1 = 32'(tagNext) + 32'd1; i_tag = tagNext;
                #1;
                fire = i_ready;
            end else begin
                i_valid = 1'b0;
                fire = 1'b0;
            end
            @(negedge clk);
            if (fire) tagNext++;
        end
        i_valid = 1'b0;
        checkOutput("stream_count", 32'(outCount), 32'd6);
        checkOutput("stream_gaps", 32'(gaps), 32'd0);
        repeat (2) @(negedge clk);

        // Flush with two ops in flight and a third handshake in the flush cycle.
        i_valid = 1'b1; i_op = 3'd0; i_lane = 2'd0; i_op1 = 32'h11; i_shamt = 5'd0; i_tag = 5'd10;
        @(negedge clk);
        i_op1 = 32'h22; i_tag = 5'd11;
        @(negedge clk);
        checkOutput("flush_pre_valid", 32'(o_valid), 32'd1);
        i_op1 = 32'h33; i_tag = 5'd12; i_flush = 1'b1;
        #1;
        checkOutput("flush_cycle_i_ready", 32'(i_ready), 32'd1);
        @(negedge clk);
        i_flush = 1'b0; i_valid = 1'b0;
        checkOutput("flush_next_valid", 32'(o_valid), 32'd0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        checkOutput("flush_no_stale", 32'(seen), 32'd0);
        applyStimulus(3'd1, 2'd0, 32'h00000100, 5'd4, 5'd13);
        waitResult(lat);
        checkOutput("post_flush_latency", 32'(lat), 32'd2);
        checkOutput("post_flush_res", o_res, 32'h00000010);
        checkOutput("post_flush_tag", 32'(o_tag), 32'd13);
        @(negedge clk);

        // Async reset with a full pipe.
        o_ready = 1'b0;
        i_valid = 1'b1; i_op = 3'd5; i_lane = 2'd0; i_op1 = 32'h40000000; i_shamt = 5'd1; i_tag = 5'd20;
        @(negedge clk);
        i_op = 3'd0; i_op1 = 32'h00000003; i_tag = 5'd21;
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        checkOutput("prereset_valid", 32'(o_valid), 32'd1);
        checkOutput("prereset_ov", 32'(o_ov), 32'd1);
        checkOutput("prereset_res", o_res, 32'h7FFFFFFF);
        checkOutput("prereset_i_ready", 32'(i_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 32'(o_valid), 32'd0);
        checkOutput("async_reset_res", o_res, 32'd0);
        checkOutput("async_reset_ov", 32'(o_ov), 32'd0);
        checkOutput("async_reset_tag", 32'(o_tag), 32'd0);
        #4;
        rst_n = 1'b1;
        @(negedge clk);
        o_ready = 1'b1;
        #1;
        checkOutput("post_reset_i_ready", 32'(i_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        checkOutput("post_reset_no_stale", 32'(seen), 32'd0);
        applyStimulus(3'd2, 2'd1, 32'h8000_0010, 5'd4, 5'd22);
        waitResult(lat);
        checkOutput("post_reset_latency", 32'(lat), 32'd2);
        checkOutput("post_reset_res", o_res, 32'hF8000001);
        checkOutput("post_reset_tag", 32'(o_tag), 32'd22);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
